hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the 5-stage RISC-V core. It drives the stall and flush inputs of the fetch/decode, decode/execute, execute/memory and memory/writeback pipeline registers, and generates the execute-stage operand forwarding selects. It also sequences multi-cycle data-memory accesses with a wait-state FSM, a timeout flag and stall/flush performance counters. It sits beside the datapath, taking register addresses and control bits from the D, E, M and W stages.

## Interface
- REG_ADDR_WIDTH, 5, register-file address width
- MEM_TIMEOUT, 16, MEM_WAIT cycle count at which MemTimeout sets
- CNT_WIDTH, 32, width of the performance counters
---
- clk  in  1  clock, rising-edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- Rs1D, Rs2D  in  REG_ADDR_WIDTH  source registers of the instruction in D
- Rs1E, Rs2E, RdE  in  REG_ADDR_WIDTH  source and destination registers in E
- MemReadE  in  1  instruction in E is a load
- PCRedirectE  in  1  taken branch or jump resolved in E
- RdM  in  REG_ADDR_WIDTH  destination register in M
- RegWriteM  in  1  M instruction writes the register file
- MemAccessM  in  1  load or store active in M
- MemReadyM  in  1  data memory completes the M access this cycle
- RdW  in  REG_ADDR_WIDTH  destination register in W
- RegWriteW  in  1  W instruction writes the register file
- StallF, StallD, StallE, StallM  out  1  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  out  1  bubble the F/D, D/E and M/W registers
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 W result, 10 M ALU result
- MemTimeout  out  1  sticky; a memory wait reached MEM_TIMEOUT
- StallCount, FlushCount  out  CNT_WIDTH  performance counters

## Operation
- Forwarding is combinational. For each source register: select 10 if RegWriteM, RdM≠0 and RdM==RsXE. Otherwise select 01 if RegWriteW, RdW≠0 and RdW==RsXE. Otherwise select 00. M has priority over W.
- memStall = MemAccessM & !MemReadyM.
  - Asserts StallF, StallD, StallE and StallM, plus FlushW.
  - Suppresses FlushD and FlushE, so stalled stages hold their contents.
- loadUse = MemReadE, RdE≠0, and RdE==Rs1D or RdE==Rs2D. It asserts StallF, StallD and FlushE for one cycle.
- PCRedirectE asserts FlushD and FlushE. It overrides loadUse, so no stall occurs in a redirect cycle.
- Priority, highest first: rst, memStall, PCRedirectE, loadUse.
- FSM states:
  - RUN → MEM_WAIT when memStall.
  - MEM_WAIT → RUN when MemReadyM. Stall outputs drop in the same cycle MemReadyM rises.
- A redirect pending in E during MEM_WAIT is held, because E is stalled. It takes effect on the release cycle.
- wait_cnt counts cycles spent in MEM_WAIT.
  - It clears on entering RUN.
  - It saturates at MEM_TIMEOUT, and MemTimeout sets at that point.
  - MemTimeout stays set until rst. Stalling continues regardless.
- Counters:
  - StallCount increments on every cycle StallF=1.
  - FlushCount increments on every cycle PCRedirectE is taken and not suppressed.
  - Both wrap modulo 2^CNT_WIDTH.

## Timing
- Reset (rst high at a rising edge):
  - State = RUN.
  - wait_cnt, MemTimeout, StallCount and FlushCount = 0.
- While rst is high, outputs are forced combinationally:
  - All Stall* = 0.
  - FlushD, FlushE and FlushW = 1.
  - ForwardAE and ForwardBE = 00.
- rst asserted during MEM_WAIT aborts the wait. State returns to RUN on the next edge.
- Stall, flush and forward outputs are combinational, with zero-cycle latency from their inputs. State, wait_cnt and the counters are registered and update on the edge.
- MemTimeout is registered. It rises on the edge where wait_cnt reaches MEM_TIMEOUT.
- Back-to-back memory accesses with MemReadyM=0 re-enter MEM_WAIT with no RUN bubble.

## Structure
- hazard_pkg holds:
  - The forward-select constants FWD_RF=2'b00, FWD_W=2'b01 and FWD_M=2'b10.
  - The state enum {RUN, MEM_WAIT}.
- Sub-module forward_select (comparator plus priority mux) is instantiated twice, once for operand A and once for operand B.

## Test plan
- Forwarding: RegWriteM=1, RdM=5, RdW=5, Rs1E=5 → ForwardAE=10. Same case with RdM=0 and RegWriteW=1 → 01. Rs2E=0 with RdW=0 → ForwardBE=00.
- Load-use: MemReadE=1, RdE=7, Rs2D=7 → StallF=StallD=FlushE=1 for exactly one cycle; StallCount +1.
- Redirect plus load-use in the same cycle: PCRedirectE=1 with the load-use condition true → FlushD=FlushE=1, StallF=0; FlushCount +1.
- Memory wait: MemAccessM=1 with MemReadyM=0 for 3 cycles then 1 → Stall F/D/E/M and FlushW high for 3 cycles; state back to RUN; StallCount +3.
- Timeout: MEM_TIMEOUT=4 with MemReadyM held at 0 → MemTimeout=1 after the 4th wait cycle; it stays 1 after release until rst.
- Reset mid-wait: rst pulsed in MEM_WAIT → next cycle state=RUN, counters=0, FlushD/E/W=1 during rst.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Datapath <-> hazard unit signal bundle; master is the datapath, slave the hazard unit.
interface hazard_unit_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
);

  logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D;
  logic [REG_ADDR_WIDTH-1:0] Rs1E, Rs2E, RdE;
  logic                      MemReadE;
  logic                      PCRedirectE;
  logic [REG_ADDR_WIDTH-1:0] RdM;
  logic                      RegWriteM;
  logic                      MemAccessM;
  logic                      MemReadyM;
  logic [REG_ADDR_WIDTH-1:0] RdW;
  logic                      RegWriteW;

  logic                      StallF, StallD, StallE, StallM;
  logic                      FlushD, FlushE, FlushW;
  logic [1:0]                ForwardAE, ForwardBE;
  logic                      MemTimeout;
  logic [CNT_WIDTH-1:0]      StallCount, FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, PCRedirectE,
           RdM, RegWriteM, MemAccessM, MemReadyM, RdW, RegWriteW,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, MemReadE, PCRedirectE,
           RdM, RegWriteM, MemAccessM, MemReadyM, RdW, RegWriteW,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, MemTimeout, StallCount, FlushCount
  );

endinterface

// File: rtl/forward_select.sv
// Operand forwarding select for one E-stage source register; M result wins over W.
module forward_select
  import hazard_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] rs_i,
  input  logic [W-1:0] rd_m_i,
  input  logic         reg_write_m_i,
  input  logic [W-1:0] rd_w_i,
  input  logic         reg_write_w_i,
  output logic [1:0]   fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
      fwd_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stall/flush generation, forwarding, memory wait-state
// sequencing with sticky timeout, and stall/flush performance counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT    = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic       clk,
  input  logic       rst,
  hazard_unit_if.slave hz
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e             state_q, state_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  logic       mem_stall, load_use, redirect_taken;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  forward_select #(.W(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_i          (hz.Rs1E),
    .rd_m_i        (hz.RdM),
    .reg_write_m_i (hz.RegWriteM),
    .rd_w_i        (hz.RdW),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (fwd_a)
  );

  forward_select #(.W(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_i          (hz.Rs2E),
    .rd_m_i        (hz.RdM),
    .reg_write_m_i (hz.RegWriteM),
    .rd_w_i        (hz.RdW),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (fwd_b)
  );

  assign mem_stall = hz.MemAccessM & ~hz.MemReadyM;
  assign load_use  = hz.MemReadE & (hz.RdE != '0) &
                     ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));

  // Stall/flush priority: rst, memory wait, redirect, load-use.
  always_comb begin
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    stall_e        = 1'b0;
    stall_m        = 1'b0;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    flush_w        = 1'b0;
    redirect_taken = 1'b0;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCRedirectE) begin
      flush_d        = 1'b1;
      flush_e        = 1'b1;
      redirect_taken = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Wait-state FSM, saturating wait counter, sticky timeout and perf counters.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    if (state_q == RUN) begin
      if (mem_stall) state_d = MEM_WAIT;
    end else begin
      if (!mem_stall) state_d = RUN;
    end
    if (state_d == MEM_WAIT) begin
      wait_cnt_d = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) ? wait_cnt_q
                                                        : wait_cnt_q + WAIT_W'(1);
    end
    timeout_d   = timeout_q | (wait_cnt_d == WAIT_W'(MEM_TIMEOUT));
    stall_cnt_d = stall_cnt_q + CNT_WIDTH'(stall_f);
    flush_cnt_d = flush_cnt_q + CNT_WIDTH'(redirect_taken);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_d;
  assign hz.StallE     = stall_e;
  assign hz.StallM     = stall_m;
  assign hz.FlushD     = flush_d;
  assign hz.FlushE     = flush_e;
  assign hz.FlushW     = flush_w;
  assign hz.ForwardAE  = rst ? FWD_RF : fwd_a;
  assign hz.ForwardBE  = rst ? FWD_RF : fwd_b;
  assign hz.MemTimeout = timeout_q;
  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;

endmodule
